// File: rtl/cute_lock_pkg.sv
// Shared constants for the Cute-Lock key sequencer and the locked FSM's counter.
// The locked FSM's window counter uses the same PERIOD / WIN_LEN values.
package cute_lock_pkg;

    localparam int KEY_W_DEF    = 16;
    localparam int NUM_KEYS_DEF = 5;
    localparam int WIN_LEN_DEF  = 10;
    localparam int PERIOD_DEF   = NUM_KEYS_DEF * WIN_LEN_DEF;
    localparam int WIN_IDX_W    = 3;

    typedef logic [0:0] seq_state_t;

    localparam seq_state_t ST_LOAD = 1'b0;
    localparam seq_state_t ST_RUN  = 1'b1;

    // Counter width that stays legal for a degenerate count of 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cute_lock_key_bank.sv
// Secret key storage: NUM_KEYS x KEY_W slots, one write port, synchronous
// clear, and a combinational read selected by window index.
module cute_lock_key_bank
    import cute_lock_pkg::*;
#(
    parameter int KEY_W    = KEY_W_DEF,
    parameter int NUM_KEYS = NUM_KEYS_DEF,
    parameter int IDX_W    = WIN_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] wptr,
    input  logic [KEY_W-1:0] wdata,
    input  logic             clr,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [KEY_W-1:0] rd_data
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_KEYS - 1);

    logic [KEY_W-1:0] slots [NUM_KEYS];

    // NOTE: the slots are reset (flop array, not RAM) so a reset or clear
    // never leaves a stale secret readable after the lock restarts.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_KEYS; i++) slots[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < NUM_KEYS; i++) slots[i] <= '0;
        end else if (we && (wptr <= IDX_LAST)) begin
            slots[wptr] <= wdata;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_idx <= IDX_LAST) rd_data = slots[rd_idx];
    end

endmodule

// File: rtl/cute_lock_key_sequencer.sv
// Trusted key source for a time-varying locked FSM: loads NUM_KEYS keys, then
// drives the key the lock expects in each WIN_LEN-cycle window, falling-edge timed.
module cute_lock_key_sequencer
    import cute_lock_pkg::*;
#(
    parameter int KEY_W    = KEY_W_DEF,
    parameter int NUM_KEYS = NUM_KEYS_DEF,
    parameter int WIN_LEN  = WIN_LEN_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [KEY_W-1:0]     ld_data,
    input  logic                 ld_clear,
    output logic [KEY_W-1:0]     key_out,
    output logic                 keys_loaded,
    output logic [WIN_IDX_W-1:0] win_idx,
    output logic                 period_sync
);

    localparam int                   POS_W    = cnt_width(WIN_LEN);
    localparam logic [POS_W-1:0]     POS_LAST = POS_W'(WIN_LEN - 1);
    localparam logic [WIN_IDX_W-1:0] WIN_LAST = WIN_IDX_W'(NUM_KEYS - 1);

    // pos/win hold the counter value the lock samples at the next falling edge.
    logic [POS_W-1:0]     pos;
    logic [WIN_IDX_W-1:0] win;
    logic [POS_W-1:0]     pos_nxt;
    logic [WIN_IDX_W-1:0] win_nxt;
    seq_state_t           state;
    logic [WIN_IDX_W-1:0] ld_ptr;
    logic [KEY_W-1:0]     bank_rd;
    logic [KEY_W-1:0]     key_rev;
    logic                 bank_we;

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        pos_nxt = pos + POS_W'(1);
        win_nxt = win;
        if (pos == POS_LAST) begin
            pos_nxt = '0;
            win_nxt = (win == WIN_LAST) ? '0 : win + WIN_IDX_W'(1);
        end
    end

    // keyinput0 takes the key word's MSB.
    always_comb begin
        key_rev = '0;
        for (int i = 0; i < KEY_W; i++) key_rev[i] = bank_rd[KEY_W-1-i];
    end

    assign bank_we = ld_valid && (state == ST_LOAD) && !ld_clear;

    cute_lock_key_bank #(
        .KEY_W    (KEY_W),
        .NUM_KEYS (NUM_KEYS),
        .IDX_W    (WIN_IDX_W)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .we      (bank_we),
        .wptr    (ld_ptr),
        .wdata   (ld_data),
        .clr     (ld_clear),
        .rd_idx  (win_nxt),
        .rd_data (bank_rd)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, matching the lock's view at the same edge.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            pos     <= '0;
            win     <= '0;
            state   <= ST_LOAD;
            ld_ptr  <= '0;
            key_out <= '0;
        end else begin
            pos <= pos_nxt;
            win <= win_nxt;
            if (ld_clear) begin
                state   <= ST_LOAD;
                ld_ptr  <= '0;
                key_out <= '0;
            end else if (state == ST_LOAD) begin
                key_out <= '0;
                if (ld_valid) begin
                    if (ld_ptr == WIN_LAST) begin
                        ld_ptr <= '0;
                        state  <= ST_RUN;
                    end else begin
                        ld_ptr <= ld_ptr + WIN_IDX_W'(1);
                    end
                end
            end else begin
                key_out <= key_rev;
            end
        end
    end

    assign ld_ready    = (state == ST_LOAD);
    assign keys_loaded = (state == ST_RUN);
    assign win_idx     = win;
    assign period_sync = (pos == '0) && (win == '0);

endmodule

// File: tb/tb_cute_lock_key_sequencer.sv
// Directed bench: mirrors the lock counter and checks the driven key every edge.
module tb_cute_lock_key_sequencer;

    logic        clk;
    logic        rst;
    logic        ld_valid;
    logic        ld_ready;
    logic [15:0] ld_data;
    logic        ld_clear;
    logic [15:0] key_out;
    logic        keys_loaded;
    logic [2:0]  win_idx;
    logic        period_sync;

    int n_checks = 0;
    int n_fail   = 0;
    int lcnt     = 0;

    logic [15:0] load_word_tbl [5] = '{16'h6225, 16'hE3CA, 16'h717E, 16'h46FD, 16'h057B};
    logic [15:0] exp_key       [5] = '{16'hA446, 16'h53C7, 16'h7E8E, 16'hBF62, 16'hDEA0};
    int          gaps          [5] = '{0, 2, 7, 1, 0};

    cute_lock_key_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_data     (ld_data),
        .ld_clear    (ld_clear),
        .key_out     (key_out),
        .keys_loaded (keys_loaded),
        .win_idx     (win_idx),
        .period_sync (period_sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (lock cnt %0d)", tag, got, exp, lcnt);
        end
    endtask

    // Advance one active (falling) edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(negedge clk);
        #1;
        lcnt = (lcnt + 1) % 50;
    endtask

    // Lock-compare model: the key presented now is what the lock samples with lcnt.
    task automatic run_lock(input int n);
        for (int i = 0; i < n; i++) begin
            check("lock_key", key_out, exp_key[lcnt / 10]);
            check("win_idx", win_idx, lcnt / 10);
            check("period_sync", period_sync, lcnt == 0);
            step();
        end
    endtask

    task automatic run_until(input int target);
        for (int i = 0; i < 50 && lcnt != target; i++) run_lock(1);
    endtask

    task automatic load_word(input logic [15:0] d, input int gap);
        ld_valid = 1'b0;
        for (int i = 0; i < gap; i++) begin
            check("gap_key_zero", key_out, 16'h0);
            check("gap_ready", ld_ready, 1'b1);
            check("gap_win_idx", win_idx, lcnt / 10);
            step();
        end
        check("load_key_zero", key_out, 16'h0);
        check("load_ready", ld_ready, 1'b1);
        check("load_not_loaded", keys_loaded, 1'b0);
        ld_valid = 1'b1;
        ld_data  = d;
        step();
        ld_valid = 1'b0;
    endtask

    // After the final transfer edge: running, but key_out is still 0 for one edge.
    task automatic arm_check();
        check("arm_loaded", keys_loaded, 1'b1);
        check("arm_ready", ld_ready, 1'b0);
        check("arm_key_zero", key_out, 16'h0);
        step();
    endtask

    initial begin
        rst      = 1'b1;
        ld_valid = 1'b0;
        ld_data  = '0;
        ld_clear = 1'b0;
        #12;
        check("rst_key", key_out, 16'h0);
        check("rst_loaded", keys_loaded, 1'b0);
        check("rst_ready", ld_ready, 1'b1);
        check("rst_win_idx", win_idx, 3'd0);
        check("rst_period_sync", period_sync, 1'b1);
        #1;
        rst  = 1'b0;
        lcnt = 0;

        // Back-to-back load, arm, then three full periods against the lock model.
        for (int k = 0; k < 5; k++) load_word(load_word_tbl[k], 0);
        arm_check();
        check("first_key", key_out, 16'hA446);
        run_lock(150);

        // ld_valid held high with all-ones data while running: ignored.
        ld_valid = 1'b1;
        ld_data  = 16'hFFFF;
        check("run_ready_low", ld_ready, 1'b0);
        run_lock(60);
        ld_valid = 1'b0;
        run_until(0);
        check("win0_unchanged", key_out, 16'hA446);

        // Clear together with a valid word in RUN; the counter keeps going.
        run_until(17);
        ld_clear = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 16'h1234;
        step();
        ld_clear = 1'b0;
        ld_valid = 1'b0;
        check("clr_key_zero", key_out, 16'h0);
        check("clr_ready", ld_ready, 1'b1);
        check("clr_loaded", keys_loaded, 1'b0);
        check("clr_win_idx", win_idx, 3'd1);
        check("clr_period_sync", period_sync, 1'b0);

        // Partial load, then clear in LOAD with a competing word that must be dropped.
        load_word(16'h1111, 0);
        load_word(16'h2222, 0);
        ld_clear = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 16'hFFFF;
        step();
        ld_clear = 1'b0;
        ld_valid = 1'b0;
        check("clr_load_ready", ld_ready, 1'b1);
        check("clr_load_key", key_out, 16'h0);

        // Reload with gaps (including 7 idle cycles); keys must come out unchanged.
        for (int k = 0; k < 5; k++) load_word(load_word_tbl[k], gaps[k]);
        arm_check();
        run_lock(60);

        // Asynchronous reset mid-run at counter 23.
        run_until(23);
        rst = 1'b1;
        #1;
        check("arst_key", key_out, 16'h0);
        check("arst_win_idx", win_idx, 3'd0);
        check("arst_period_sync", period_sync, 1'b1);
        check("arst_loaded", keys_loaded, 1'b0);
        check("arst_ready", ld_ready, 1'b1);
        #1;
        rst  = 1'b0;
        lcnt = 0;
        step();
        check("post_rst_key", key_out, 16'h0);
        check("post_rst_win_idx", win_idx, 3'd0);

        // A fresh load after reset relies on ld_ptr having returned to 0.
        for (int k = 0; k < 5; k++) load_word(load_word_tbl[k], 0);
        arm_check();
        run_lock(55);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
